// File: rtl/seg7_scan_driver_pkg.sv
// Shared seven-segment constants: blank codes, hex glyph table, BCD register address.
// Latency: n/a (constants and a combinational lookup helper).
// Backpressure: n/a.
package seg7_scan_driver_pkg;

   localparam logic [7:0]  SEG_BLANK     = 8'hFF;   // all segments and dp off (active-low)
   localparam logic [3:0]  AN_OFF        = 4'hF;    // all anodes off (active-low)
   localparam logic [31:0] BCD_MMIO_ADDR = 32'h4000_0010;

   // Active-high {g,f,e,d,c,b,a} glyphs, indexed by nibble value 0..F.
   localparam logic [15:0][6:0] HEX7_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
      7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
      7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
      7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
   };

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      return HEX7_TABLE[nib];
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to seven-segment glyph decoder (active-high gfedcba).
// Latency: combinational.
// Backpressure: none.
// Ports: nibble (4-bit value in), pattern (7-bit glyph out).
module seg7_hex_decode
   import seg7_scan_driver_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] pattern
);

   assign pattern = hex7(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Scans a frame-latched 16-bit BCD word onto a 4-digit common-anode display.
// Latency: an/seg registered, 1 cycle after the scan/pwm/shadow state they reflect.
// Backpressure: none; BCD/dp_in are sampled only at the frame boundary.
// Ports: clk, reset (async active-low), BCD[15:0], blank_lz, dp_in[3:0],
//        brightness[PWM_BITS-1:0] -> an[3:0], seg[7:0] ({dp,g..a}, active-low), frame_tick.
module seg7_scan_driver
   import seg7_scan_driver_pkg::*;
#(
   parameter int SCAN_DIV = 100000,
   parameter int PWM_BITS = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [15:0]         BCD,
   input  logic                blank_lz,
   input  logic [3:0]          dp_in,
   input  logic [PWM_BITS-1:0] brightness,
   output logic [3:0]          an,
   output logic [7:0]          seg,
   output logic                frame_tick
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [DIV_W-1:0]    div_cnt;
   logic [1:0]          idx;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [15:0]         shadow;
   logic [3:0]          dp_shadow;

   logic                slot_end;
   logic                frame_end;
   logic [3:0]          nibble;
   logic [6:0]          pattern;
   logic                upper_zero;
   logic                blank;

   assign slot_end  = (div_cnt == DIV_W'(SCAN_DIV - 1));
   assign frame_end = slot_end && (idx == 2'd3);

   always_comb begin
      nibble = shadow[{idx, 2'b00} +: 4];
   end

   // A digit is a leading zero when it and every more-significant nibble are zero;
   // the rightmost digit always shows so a zero value still reads "0".
   always_comb begin
      upper_zero = 1'b0;
      case (idx)
         2'd0:    upper_zero = 1'b0;
         2'd1:    upper_zero = (shadow[15:4]  == 12'h000);
         2'd2:    upper_zero = (shadow[15:8]  == 8'h00);
         default: upper_zero = (shadow[15:12] == 4'h0);
      endcase
   end

   assign blank = blank_lz && upper_zero;

   seg7_hex_decode u_hex_decode (
      .nibble  (nibble),
      .pattern (pattern)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt    <= '0;
         idx        <= 2'd0;
         pwm_cnt    <= '0;
         shadow     <= 16'h0000;
         dp_shadow  <= 4'h0;
         frame_tick <= 1'b0;
         an         <= AN_OFF;
         seg        <= SEG_BLANK;
      end else begin
         pwm_cnt    <= pwm_cnt + 1'b1;
         frame_tick <= frame_end;

         if (slot_end) begin
            div_cnt <= '0;
            idx     <= idx + 2'd1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end

         // Latch the display word only between frames so a mid-frame write never tears.
         if (frame_end) begin
            shadow    <= BCD;
            dp_shadow <= dp_in;
         end

         an  <= (blank || (pwm_cnt > brightness)) ? AN_OFF : ~(4'b0001 << idx);
         seg <= blank ? SEG_BLANK : {~dp_shadow[idx], ~pattern};
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with SCAN_DIV=4, PWM_BITS=3.
// A frame-counting reference model checks an/seg/frame_tick every cycle;
// directed literals pin the model at known slots.
module tb_seg7_scan_driver;

   localparam int SD = 4;
   localparam int FR = 4 * SD;

   logic        clk;
   logic        reset;
   logic [15:0] BCD;
   logic        blank_lz;
   logic [3:0]  dp_in;
   logic [2:0]  brightness;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic        frame_tick;

   int n_pass  = 0;
   int n_total = 0;

   seg7_scan_driver #(.SCAN_DIV(SD), .PWM_BITS(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .BCD        (BCD),
      .blank_lz   (blank_lz),
      .dp_in      (dp_in),
      .brightness (brightness),
      .an         (an),
      .seg        (seg),
      .frame_tick (frame_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   // State is "edges since reset release"; scan position, pwm phase and frame
   // boundaries all follow from that count by plain division.
   logic [3:0] e_an;
   logic [7:0] e_seg;
   logic       e_ft;

   initial begin
      logic [6:0]  hex_ref [16];
      int          m_n;
      logic [15:0] m_sh;
      logic [3:0]  m_dp;
      int          d;
      int          p;
      logic [3:0]  nib;
      logic        blk;
      hex_ref = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      m_n = 0; m_sh = 16'h0; m_dp = 4'h0;
      e_an = 4'hF; e_seg = 8'hFF; e_ft = 1'b0;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            m_n = 0; m_sh = 16'h0; m_dp = 4'h0;
            e_an = 4'hF; e_seg = 8'hFF; e_ft = 1'b0;
         end else begin
            d   = (m_n / SD) % 4;
            p   = m_n % 8;
            nib = 4'((m_sh >> (4 * d)) & 16'hF);
            blk = blank_lz && (d != 0) && ((m_sh >> (4 * d)) == 16'h0);
            e_an = 4'hF;
            if (!blk && (p <= int'(brightness))) e_an[d] = 1'b0;
            e_seg = blk ? 8'hFF : {~m_dp[d], ~hex_ref[nib]};
            e_ft  = ((m_n % FR) == FR - 1);
            if (e_ft) begin
               m_sh = BCD;
               m_dp = dp_in;
            end
            m_n++;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         check("cycle", {19'h0, an, seg, frame_tick}, {19'h0, e_an, e_seg, e_ft});
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_tick(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!frame_tick && cyc < 40);
      if (!frame_tick) begin
         n_total++;
         $display("FAIL tick_timeout: no frame_tick within %0d cycles", cyc);
      end
   endtask

   // Called right after a frame_tick was seen: samples each digit slot of the new frame.
   task automatic check_slots(input string tag, input logic [31:0] segs, input logic [15:0] ans);
      repeat (2) @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         if (s > 0) repeat (4) @(negedge clk);
         check($sformatf("%s_d%0d_seg", tag, s), {24'h0, seg}, {24'h0, segs[8*s +: 8]});
         check($sformatf("%s_d%0d_an", tag, s), {28'h0, an}, {28'h0, ans[4*s +: 4]});
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int k;
      int c;
      int on_cnt;
      logic [15:0] sweep [4];
      sweep = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};

      reset = 1'b0; BCD = 16'h12AF; blank_lz = 1'b0; dp_in = 4'h0; brightness = 3'd7;
      repeat (5) @(negedge clk);
      check("reset_an", {28'h0, an}, 32'hF);
      check("reset_seg", {24'h0, seg}, 32'hFF);
      check("reset_ft", {31'h0, frame_tick}, 32'h0);

      reset = 1'b1;
      k = 0;
      while (k < 40) begin
         @(negedge clk);
         k++;
         if (frame_tick) break;
      end
      check("first_tick_cycle", k, 16);
      wait_tick(c);
      check("tick_period", c, 16);
      check_slots("hex12AF", 32'hF9A4_888E, 16'h7BDE);

      // leading-zero blanking
      BCD = 16'h0050; blank_lz = 1'b1;
      wait_tick(c);
      check_slots("lz0050", 32'hFFFF_92C0, 16'hFFDE);
      BCD = 16'h0000;
      wait_tick(c);
      check_slots("lz0000", 32'hFFFF_FFC0, 16'hFFFE);

      // mid-frame update must not tear the current frame
      blank_lz = 1'b0; BCD = 16'h1234;
      wait_tick(c);
      repeat (6) @(negedge clk);
      BCD = 16'h5678;
      repeat (4) @(negedge clk);
      check("tear_d2_seg", {24'h0, seg}, 32'hA4);
      check("tear_d2_an", {28'h0, an}, 32'hB);
      repeat (4) @(negedge clk);
      check("tear_d3_seg", {24'h0, seg}, 32'hF9);
      wait_tick(c);
      check_slots("hex5678", 32'h9282_F880, 16'h7BDE);

      // all glyphs, with varying decimal points; checked by the model
      for (int i = 0; i < 4; i++) begin
         BCD = sweep[i];
         dp_in = 4'(4'b1010 >> (i % 2));
         wait_tick(c);
      end
      wait_tick(c);

      // minimum brightness and decimal point on digit 0
      brightness = 3'd0; dp_in = 4'b0001; BCD = 16'h0000;
      wait_tick(c);
      @(negedge clk);
      check("dp_d0_seg", {24'h0, seg}, 32'h40);
      check("pwm_on_d0_an", {28'h0, an}, 32'hE);
      on_cnt = (an != 4'hF) ? 1 : 0;
      repeat (15) begin
         @(negedge clk);
         if (an != 4'hF) on_cnt++;
      end
      check("pwm_duty_per_frame", on_cnt, 2);

      // asynchronous reset in the middle of a frame
      brightness = 3'd7; dp_in = 4'h0; BCD = 16'h9999;
      wait_tick(c);
      repeat (10) @(negedge clk);
      #1 reset = 1'b0;
      #1;
      check("midreset_an", {28'h0, an}, 32'hF);
      check("midreset_seg", {24'h0, seg}, 32'hFF);
      check("midreset_ft", {31'h0, frame_tick}, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("restart_d0_seg", {24'h0, seg}, 32'hC0);
      check("restart_d0_an", {28'h0, an}, 32'hE);
      wait_tick(c);
      check("restart_tick_cycle", c + 2, 16);
      check_slots("hex9999", 32'h9090_9090, 16'h7BDE);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
